// File: rtl/qupls_regfile_wrrouter.sv
// Routes up to NCH functional-unit results onto NPORT register-file write ports via per-channel
// one-entry holding registers. Define QUPLS_RFROUT_RR_EN for rotating priority (default: fixed).
module qupls_regfile_wrrouter #(
  parameter int unsigned NCH    = 12,
  parameter int unsigned NPORT  = 4,
  parameter int unsigned AREG_W = 7,
  parameter int unsigned PREG_W = 9,
  parameter int unsigned VAL_W  = 64
) (
  input  logic                           rst,
  input  logic                           clk,
  input  logic [NCH-1:0]                 fu_v,
  output logic [NCH-1:0]                 fu_rdy,
  input  logic [NCH-1:0][AREG_W-1:0]     fu_aRt,
  input  logic [NCH-1:0][PREG_W-1:0]     fu_Rt,
  input  logic [NCH-1:0][VAL_W-1:0]      fu_res,
  input  logic [NCH-1:0]                 fu_tag,
  output logic [NPORT-1:0]               wp_v,
  output logic [NPORT-1:0][AREG_W-1:0]   wp_aRt,
  output logic [NPORT-1:0][PREG_W-1:0]   wp_Rt,
  output logic [NPORT-1:0][VAL_W-1:0]    wp_res,
  output logic [NPORT-1:0]               wp_tag,
  output logic [NPORT-1:0][3:0]          wp_ch,
  output logic                           stall,
  output logic [31:0]                    stall_cnt
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]               r_hold_v;
  logic [NCH-1:0][AREG_W-1:0]   r_hold_aRt;
  logic [NCH-1:0][PREG_W-1:0]   r_hold_Rt;
  logic [NCH-1:0][VAL_W-1:0]    r_hold_res;
  logic [NCH-1:0]               r_hold_tag;

  logic [NCH-1:0]               w_grant;
  logic [NCH-1:0]               w_cap;
  logic [NPORT-1:0]             w_port_v;
  logic [NPORT-1:0][3:0]        w_port_ch;
  logic [PW-1:0]                w_start;
  logic                         w_stall_d;

`ifdef QUPLS_RFROUT_RR_EN
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_last;
  logic [PW-1:0] w_ptr_d;

  assign w_start = r_ptr;
  assign w_ptr_d = (w_last == PW'(NCH - 1)) ? '0 : w_last + 1'b1;
`else
  assign w_start = '0;
`endif

  // Walk channels in priority order from w_start; the n-th held channel found goes to port n.
  always_comb begin
    int unsigned idx;
    int unsigned cnt;
    w_grant   = '0;
    w_port_v  = '0;
    w_port_ch = '0;
    cnt       = 0;
`ifdef QUPLS_RFROUT_RR_EN
    w_last    = '0;
`endif
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(w_start) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (r_hold_v[idx] && cnt < NPORT) begin
        w_grant[idx]   = 1'b1;
        w_port_v[cnt]  = 1'b1;
        w_port_ch[cnt] = 4'(idx);
`ifdef QUPLS_RFROUT_RR_EN
        w_last         = PW'(idx);
`endif
        cnt            = cnt + 1;
      end
    end
  end

  assign fu_rdy    = ~r_hold_v | w_grant;
  assign w_cap     = fu_v & fu_rdy;
  assign w_stall_d = |(r_hold_v & ~w_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_v  <= '0;
      wp_v      <= '0;
      wp_aRt    <= '0;
      wp_Rt     <= '0;
      wp_res    <= '0;
      wp_tag    <= '0;
      wp_ch     <= '0;
      stall     <= 1'b0;
      stall_cnt <= '0;
`ifdef QUPLS_RFROUT_RR_EN
      r_ptr     <= '0;
`endif
    end else begin
      // A granted channel that captures in the same cycle stays full with the new payload.
      r_hold_v <= w_cap | (r_hold_v & ~w_grant);
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) begin
          r_hold_aRt[i] <= fu_aRt[i];
          r_hold_Rt[i]  <= fu_Rt[i];
          r_hold_res[i] <= fu_res[i];
          r_hold_tag[i] <= fu_tag[i];
        end
      end
      wp_v <= w_port_v;
      for (int p = 0; p < NPORT; p++) begin
        if (w_port_v[p]) begin
          wp_aRt[p] <= r_hold_aRt[w_port_ch[p]];
          wp_Rt[p]  <= r_hold_Rt[w_port_ch[p]];
          wp_res[p] <= r_hold_res[w_port_ch[p]];
          wp_tag[p] <= r_hold_tag[w_port_ch[p]];
          wp_ch[p]  <= w_port_ch[p];
        end
      end
      stall <= w_stall_d;
      if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
`ifdef QUPLS_RFROUT_RR_EN
      if (|w_grant) r_ptr <= w_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_qupls_regfile_wrrouter.sv
// Randomized bench for qupls_regfile_wrrouter against a queue-based reference model of the
// holding/grant rules; honours QUPLS_RFROUT_RR_EN for the rotating-priority build.
module tb_qupls_regfile_wrrouter;

  localparam int unsigned NCH   = 12;
  localparam int unsigned NPORT = 4;
  localparam int unsigned AW    = 7;
  localparam int unsigned RW    = 9;
  localparam int unsigned VW    = 64;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NCH-1:0]            fu_v = '0;
  logic [NCH-1:0]            fu_rdy;
  logic [NCH-1:0][AW-1:0]    fu_aRt = '0;
  logic [NCH-1:0][RW-1:0]    fu_Rt = '0;
  logic [NCH-1:0][VW-1:0]    fu_res = '0;
  logic [NCH-1:0]            fu_tag = '0;
  logic [NPORT-1:0]          wp_v;
  logic [NPORT-1:0][AW-1:0]  wp_aRt;
  logic [NPORT-1:0][RW-1:0]  wp_Rt;
  logic [NPORT-1:0][VW-1:0]  wp_res;
  logic [NPORT-1:0]          wp_tag;
  logic [NPORT-1:0][3:0]     wp_ch;
  logic                      stall;
  logic [31:0]               stall_cnt;

  qupls_regfile_wrrouter #(
    .NCH    (NCH),
    .NPORT  (NPORT),
    .AREG_W (AW),
    .PREG_W (RW),
    .VAL_W  (VW)
  ) dut (
    .rst       (rst),
    .clk       (clk),
    .fu_v      (fu_v),
    .fu_rdy    (fu_rdy),
    .fu_aRt    (fu_aRt),
    .fu_Rt     (fu_Rt),
    .fu_res    (fu_res),
    .fu_tag    (fu_tag),
    .wp_v      (wp_v),
    .wp_aRt    (wp_aRt),
    .wp_Rt     (wp_Rt),
    .wp_res    (wp_res),
    .wp_tag    (wp_tag),
    .wp_ch     (wp_ch),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one slot per channel, expected port contents, stall state.
  bit              m_hv  [NCH];
  logic [AW-1:0]   m_aRt [NCH];
  logic [RW-1:0]   m_Rt  [NCH];
  logic [VW-1:0]   m_res [NCH];
  logic            m_tag [NCH];
  int              m_ptr;
  bit              m_stall;
  longint unsigned m_cnt;
  logic [NPORT-1:0] e_v;
  logic [84:0]     e_pay [NPORT];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_hv[i] = 1'b0;
    m_ptr   = 0;
    m_stall = 1'b0;
    m_cnt   = 0;
    e_v     = '0;
    for (int p = 0; p < NPORT; p++) e_pay[p] = '0;
  endtask

  // One clock: drive inputs, check fu_rdy before the edge, advance model, check outputs after.
  task automatic run_cycle(input logic [NCH-1:0] fv, input bit do_rst, input bit rnd);
    int             g[$];
    logic [NCH-1:0] gr;
    logic [NCH-1:0] erdy;
    int             held;
    rst  = do_rst;
    fu_v = fv;
    if (rnd) begin
      for (int i = 0; i < NCH; i++) begin
        fu_aRt[i] = AW'($urandom);
        fu_Rt[i]  = RW'($urandom);
        fu_res[i] = {$urandom, $urandom};
        fu_tag[i] = 1'($urandom);
      end
    end
    gr   = '0;
    held = 0;
    for (int k = 0; k < NCH; k++) begin
      int ch;
      ch = (m_ptr + k) % NCH;
      if (m_hv[ch]) begin
        held++;
        if (g.size() < int'(NPORT)) begin
          g.push_back(ch);
          gr[ch] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NCH; i++) erdy[i] = !m_hv[i] || gr[i];
    #1;
    if (!do_rst) check("fu_rdy", 128'(fu_rdy), 128'(erdy));
    @(posedge clk);
    if (do_rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (p < g.size()) begin
          e_v[p]   = 1'b1;
          e_pay[p] = {m_aRt[g[p]], m_Rt[g[p]], m_tag[g[p]], 4'(g[p]), m_res[g[p]]};
        end else begin
          e_v[p] = 1'b0;
        end
      end
      if (m_stall && m_cnt != 64'hFFFF_FFFF) m_cnt++;
      m_stall = held > g.size();
      for (int i = 0; i < NCH; i++) begin
        if (fv[i] && erdy[i]) begin
          m_hv[i]  = 1'b1;
          m_aRt[i] = fu_aRt[i];
          m_Rt[i]  = fu_Rt[i];
          m_res[i] = fu_res[i];
          m_tag[i] = fu_tag[i];
        end else if (gr[i]) begin
          m_hv[i] = 1'b0;
        end
      end
`ifdef QUPLS_RFROUT_RR_EN
      if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NCH;
`endif
    end
    #1;
    check("wp_v", 128'(wp_v), 128'(e_v));
    for (int p = 0; p < NPORT; p++) begin
      if (e_v[p] || do_rst)
        check("wp_pay", 128'({wp_aRt[p], wp_Rt[p], wp_tag[p], wp_ch[p], wp_res[p]}),
              128'(e_pay[p]));
    end
    check("stall", 128'(stall), 128'(m_stall));
    check("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    run_cycle('0, 1'b1, 1'b1);
    run_cycle('0, 1'b1, 1'b1);

    // Single result on channel 0.
    fu_Rt[0]  = RW'(9);
    fu_res[0] = 64'hA5;
    run_cycle(12'h001, 1'b0, 1'b0);
    run_cycle(12'h000, 1'b0, 1'b1);
    check("r050_wp_v", 128'(wp_v), 128'(4'b0001));
    check("r050_rt", 128'(wp_Rt[0]), 128'(9));
    check("r050_res", 128'(wp_res[0]), 128'(64'hA5));
    check("r050_ch", 128'(wp_ch[0]), 128'(0));
    check("r050_stall", 128'(stall), 128'(0));

    // All channels at once drain in three cycles.
    run_cycle('0, 1'b1, 1'b1);
    run_cycle(12'hFFF, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      run_cycle('0, 1'b0, 1'b1);
      check("r051_wp_v", 128'(wp_v), 128'(4'hF));
    end
    run_cycle('0, 1'b0, 1'b1);
    check("r051_cnt", 128'(stall_cnt), 128'(2));
    check("r051_rdy", 128'(fu_rdy), 128'(12'hFFF));

    // Constant pressure on the low eight channels, with same-cycle recapture.
    run_cycle('0, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) run_cycle(12'h0FF, 1'b0, 1'b1);
`ifndef QUPLS_RFROUT_RR_EN
    check("r052_rdy_hi", 128'(fu_rdy[7:4]), 128'(0));
`endif
    for (int c = 0; c < 4; c++) run_cycle('0, 1'b0, 1'b1);

    // Reset with eight results held discards them.
    run_cycle('0, 1'b1, 1'b1);
    run_cycle(12'h0FF, 1'b0, 1'b1);
    run_cycle('0, 1'b1, 1'b1);
    check("r055_wp_v", 128'(wp_v), 128'(0));
    check("r055_cnt", 128'(stall_cnt), 128'(0));
    for (int c = 0; c < 3; c++) begin
      run_cycle('0, 1'b0, 1'b1);
      check("r055_none", 128'(wp_v), 128'(0));
    end

    // Random traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      logic [NCH-1:0] fv;
      case ($urandom_range(0, 2))
        0:       fv = NCH'($urandom);
        1:       fv = NCH'($urandom) & NCH'($urandom);
        default: fv = NCH'($urandom) | NCH'($urandom);
      endcase
      run_cycle(fv, $urandom_range(0, 49) == 0, 1'b1);
    end
    for (int c = 0; c < 4; c++) run_cycle('0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qupls_regfile_wrrouter.md
QUPLS_REGFILE_WRROUTER -- requirements
Module: qupls_regfile_wrrouter

Interface
REQ-001 Parameter NCH, default 12, number of functional-unit result channels (2..16).
REQ-002 Parameter NPORT, default 4, number of register-file write ports (1..NCH).
REQ-003 Ports (name, direction, width, meaning):
- rst  in  1  reset; one clock; synchronous, active-high.
- clk  in  1  clock; all state updates on the rising edge.
- fu_v  in  NCH  channel result valid.
- fu_rdy  out  NCH  channel may present a result this cycle.
- fu_aRt  in  NCH x aregno_t  architectural target register.
- fu_Rt  in  NCH x pregno_t  physical target register.
- fu_res  in  NCH x value_t  result value.
- fu_tag  in  NCH  result tag bit.
- wp_v  out  NPORT  write-port valid, registered.
- wp_aRt  out  NPORT x aregno_t  registered.
- wp_Rt  out  NPORT x pregno_t  registered.
- wp_res  out  NPORT x value_t  registered.
- wp_tag  out  NPORT  registered.
- wp_ch  out  NPORT x 4  source channel index, registered.
- stall  out  1  registered; some held result was not granted last cycle.
- stall_cnt  out  32  count of cycles with stall high.

Function
REQ-010 Each channel SHALL have a single-entry holding register (hold_v plus payload).
REQ-011 fu_rdy[i] SHALL equal ~hold_v[i] | grant[i], combinationally.
REQ-012 A result SHALL be captured when fu_v[i] & fu_rdy[i]; fu_v without fu_rdy SHALL be ignored, and the FU is required to hold it.
REQ-013 grant SHALL select up to NPORT channels with hold_v set, and no channel more than once per cycle.
REQ-014 Granted channels SHALL map to ports in ascending priority order: port 0 gets the highest-priority channel. Ports without a grant SHALL load wp_v=0.
REQ-015 On each edge, granted payloads SHALL load wp_*, and wp_ch SHALL get the channel index.
REQ-016 hold_v[i] SHALL clear on grant unless a new result is captured in the same cycle, in which case it stays set with the new payload.
REQ-017 Latency: a result captured at edge k, if granted, SHALL appear on wp_* after edge k+1.
REQ-018 With all NCH held and no new input, draining SHALL take exactly ceil(NCH/NPORT) cycles (3 at defaults).
REQ-019 stall SHALL register (|hold_v) & ~(all held channels granted).
REQ-020 stall_cnt SHALL increment when stall is 1 and saturate at 32'hFFFFFFFF.
REQ-021 Payload bits SHALL pass through unmodified. Same-Rt collisions are not checked.

Reset
REQ-030 While rst=1, at each edge: hold_v=0, wp_v=0, wp_aRt/wp_Rt/wp_res=0, wp_tag=0, wp_ch=0, stall=0, stall_cnt=0, priority pointer=0.
REQ-031 Reset in mid-drain SHALL discard all held results.
REQ-032 fu_rdy SHALL be all ones in the first cycle after rst deasserts.

Configuration
REQ-040 With QUPLS_RFROUT_RR_EN defined, priority SHALL rotate starting at pointer p. p SHALL become (last granted channel + 1) mod NCH after any cycle with a grant, and stay unchanged otherwise.
REQ-041 With QUPLS_RFROUT_RR_EN undefined, priority SHALL be fixed, lowest channel index first. No pointer register SHALL exist.

Verification
REQ-050 Reset, then fu_v=12'h001 with fu_Rt[0]=9, fu_res[0]=64'hA5 -> one cycle later wp_v=4'b0001, wp_Rt[0]=9, wp_res[0]=64'hA5, wp_ch[0]=0, stall=0.
REQ-051 fu_v=12'hFFF for one cycle, then 0 -> wp_v=4'hF for 3 consecutive cycles covering all 12 channels once; stall=1 for 2 cycles; stall_cnt=2; fu_rdy returns to 12'hFFF.
REQ-052 Fixed priority, fu_v=12'h0FF held constant -> channels 4..7 never granted; fu_rdy[7:4]=0 continuously; stall_cnt increments every cycle.
REQ-053 RR enabled, same stimulus as REQ-052 -> grants alternate between {0..3} and {4..7}; each channel is granted once every 2 cycles.
REQ-054 Channel 2 granted while fu_v[2]=1 with a new payload in the same cycle -> hold_v[2] stays 1, the new payload goes out the next cycle, and no result is lost or duplicated.
REQ-055 rst asserted with 8 results held -> next cycle wp_v=0, stall=0, stall_cnt=0, and no held result appears after reset.
